demo_rgb_panel_sweep: RTL

//  Parametrised test-pattern source for the HDMI overlay video path. Draws NPANELS solid colour panels

---
 rtl/demo_rgb_panel_sweep.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/demo_rgb_panel_sweep.sv
// Test-pattern source: NPANELS palette panels over a ping-pong grey gradient, all on the pixel clock.
// Define DEMO_RGB_PANEL_BORDER_EN to draw a white one-pixel border around every panel.
module demo_rgb_panel_sweep #(
    parameter int COORDSPC    = 16,
    parameter int COLSPC      = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int NPANELS     = 3,
    parameter int MARGIN_X    = 20,
    parameter int GAP_Y       = 20,
    parameter int BG_STEP     = 1,
    parameter int HOLD_FRAMES = 60
) (
    input  logic                       video_clk_pix,
    input  logic                       video_rst,
    input  logic                       video_enable,
    input  logic                       frame_start,
    input  logic                       line_start,
    input  logic signed [COORDSPC-1:0] sx,
    input  logic signed [COORDSPC-1:0] sy,
    output logic        [COLSPC-1:0]   red,
    output logic        [COLSPC-1:0]   green,
    output logic        [COLSPC-1:0]   blue,
    output logic                       de_out
);

    localparam int PH   = (V_RES - (NPANELS + 1) * GAP_Y) / NPANELS;
    localparam int X_LO = MARGIN_X + 1;
    localparam int X_HI = H_RES - 1 - MARGIN_X;
    localparam int HCW  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [COLSPC-1:0] CMAX      = '1;
    localparam logic [COLSPC-1:0] CZERO     = '0;
    localparam logic [COLSPC-1:0] CGREY     = CMAX >> 1;
    localparam logic [COLSPC-1:0] CSTEP     = COLSPC'(BG_STEP);
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(HOLD_FRAMES - 1);

    typedef struct packed {
        logic              down;
        logic [COLSPC-1:0] v;
    } pp_t;

    typedef enum logic {ST_HOLD, ST_ADVANCE} rot_state_e;

    // Saturating bounce between 0 and MAX; the value never wraps.
    function automatic pp_t pp_step(input pp_t cur);
        pp_t nxt;
        nxt = cur;
        if (!cur.down) begin
            if (cur.v >= CMAX - CSTEP) begin
                nxt.v    = CMAX;
                nxt.down = 1'b1;
            end else begin
                nxt.v = cur.v + CSTEP;
            end
        end else begin
            if (cur.v <= CSTEP) begin
                nxt.v    = CZERO;
                nxt.down = 1'b0;
            end else begin
                nxt.v = cur.v - CSTEP;
            end
        end
        return nxt;
    endfunction

    function automatic logic [3*COLSPC-1:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return {CMAX,  CZERO, CZERO};
            3'd1:    return {CZERO, CMAX,  CZERO};
            3'd2:    return {CZERO, CZERO, CMAX};
            3'd3:    return {CMAX,  CMAX,  CZERO};
            3'd4:    return {CZERO, CMAX,  CMAX};
            3'd5:    return {CMAX,  CZERO, CMAX};
            3'd6:    return {CMAX,  CMAX,  CMAX};
            default: return {CGREY, CGREY, CGREY};
        endcase
    endfunction

    logic [COLSPC-1:0] red_q, green_q, blue_q;
    logic              de_out_q;
    pp_t               bg_start_q, bg_start_d;
    pp_t               bg_line_q, bg_line_d;
    logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [2:0]        rot_q, rot_d;
    rot_state_e        state_q, state_d;

    int                sx_i, sy_i;
    logic              hit;
    logic [2:0]        hit_k;
    logic [2:0]        pal_idx;
    logic [3*COLSPC-1:0] rgb_d;
`ifdef DEMO_RGB_PANEL_BORDER_EN
    logic              on_border;
`endif

    // Panel hit test; panels never overlap, so at most one k matches.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sx_i  = int'(sx);
        sy_i  = int'(sy);
        hit   = 1'b0;
        hit_k = '0;
`ifdef DEMO_RGB_PANEL_BORDER_EN
        on_border = 1'b0;
`endif
        for (int k = 0; k < NPANELS; k++) begin
            if (sx_i >= X_LO && sx_i <= X_HI &&
                sy_i >= GAP_Y + k * (PH + GAP_Y) &&
                sy_i <= GAP_Y + k * (PH + GAP_Y) + PH - 1) begin
                hit   = 1'b1;
                hit_k = 3'(k);
`ifdef DEMO_RGB_PANEL_BORDER_EN
                on_border = (sx_i == X_LO) || (sx_i == X_HI) ||
                            (sy_i == GAP_Y + k * (PH + GAP_Y)) ||
                            (sy_i == GAP_Y + k * (PH + GAP_Y) + PH - 1);
`endif
            end
        end
    end

    always_comb begin
        pal_idx = hit_k + rot_q;
        rgb_d   = '0;
        if (video_enable) begin
            if (hit) begin
`ifdef DEMO_RGB_PANEL_BORDER_EN
                rgb_d = on_border ? {CMAX, CMAX, CMAX} : palette(pal_idx);
`else
                rgb_d = palette(pal_idx);
`endif
            end else begin
                rgb_d = {bg_line_q.v, bg_line_q.v, bg_line_q.v};
            end
        end
    end

    // Gradient and rotation next state. A line at sy==0 picks up the frame gradient as it
    // stood before any same-cycle frame_start step.
    always_comb begin
        bg_start_d = bg_start_q;
        bg_line_d  = bg_line_q;
        hold_cnt_d = hold_cnt_q;
        rot_d      = rot_q;
        state_d    = ST_HOLD;
        if (state_q == ST_ADVANCE) begin
            rot_d = rot_q + 3'd1;
        end
        if (frame_start) begin
            bg_start_d = pp_step(bg_start_q);
            if (hold_cnt_q == HOLD_LAST) begin
                hold_cnt_d = '0;
                state_d    = ST_ADVANCE;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
        if (line_start) begin
            bg_line_d = (sy == '0) ? bg_start_q : pp_step(bg_line_q);
        end
    end

    always_ff @(posedge video_clk_pix) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is tested first so it
        // overrides any strobe arriving in the same cycle.
        if (video_rst) begin
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            de_out_q   <= 1'b0;
            bg_start_q <= '0;
            bg_line_q  <= '0;
            hold_cnt_q <= '0;
            rot_q      <= '0;
            state_q    <= ST_HOLD;
        end else begin
            {red_q, green_q, blue_q} <= rgb_d;
            de_out_q   <= video_enable;
            bg_start_q <= bg_start_d;
            bg_line_q  <= bg_line_d;
            hold_cnt_q <= hold_cnt_d;
            rot_q      <= rot_d;
            state_q    <= state_d;
        end
    end

    assign red    = red_q;
    assign green  = green_q;
    assign blue   = blue_q;
    assign de_out = de_out_q;

endmodule
